// File: rtl/mult_accumulate.sv
// -----------------------------------------------------------------------------
// mult_accumulate
//
// Accumulation stage placed behind a pipelined multiplier with a fixed
// 2-cycle latency. A run of `len` operand issues is sequenced through the
// issue_valid/issue_ready handshake. A two-stage valid pipe follows each issue
// through the multiplier. Every returning product `y` is added into a wide
// accumulator, and the final sum is offered on a valid/ready result port.
//
// Optional feature (compile-time macro):
//   MACC_SATURATE_EN - defined:   the accumulator clamps to all-ones on carry
//                                 out, and overflow is set.
//                      undefined: the accumulator wraps modulo 2^ACCW, and
//                                 overflow is still set.
//
// Parameters:
//   WIDTH  multiplier operand width (y is 2*WIDTH bits)
//   ACCW   accumulator width, ACCW >= 2*WIDTH
//   LEN_W  width of the run-length field
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a run (sampled only in IDLE)
//   len          in   number of products in the run (sampled with start)
//   issue_valid  in   source drives a valid a/b pair to the multiplier
//   issue_ready  out  block accepts an issue this cycle (high only in RUN)
//   y            in   multiplier product
//   acc_out      out  accumulated sum
//   out_valid    out  acc_out is final
//   out_ready    in   consumer accepts the result
//   busy         out  state != IDLE
//   overflow     out  sticky: the sum exceeded ACCW bits during this run
// -----------------------------------------------------------------------------
module mult_accumulate #(
    parameter int WIDTH = 32,
    parameter int ACCW  = 72,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [2*WIDTH-1:0] y,
    output logic [ACCW-1:0]    acc_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [LEN_W-1:0]  issue_cnt_r;
    logic [1:0]        vp_r;
    logic [ACCW-1:0]   acc_r;
    logic              overflow_r;
    logic              issue_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic              fire_s;
    logic [ACCW:0]     sum_s;
    logic [ACCW-1:0]   acc_next_s;

    // Issue handshake and one-bit-wider accumulator sum.
    always_comb begin
        fire_s = 1'b0;
        sum_s  = {(ACCW+1){1'b0}};
        // issue_ready_r is high only in RUN, so issue_valid is ignored elsewhere.
        fire_s = issue_valid && issue_ready_r;
        sum_s  = {1'b0, acc_r} + {{(ACCW+1-2*WIDTH){1'b0}}, y};
    end

    // Next accumulator value: clamp or wrap on carry out of bit ACCW-1.
    always_comb begin
        acc_next_s = {ACCW{1'b0}};
`ifdef MACC_SATURATE_EN
        // Once at all-ones, any further nonzero product carries again, so the
        // clamp holds for the rest of the run without an extra flag.
        if (sum_s[ACCW]) begin
            acc_next_s = {ACCW{1'b1}};
        end else begin
            acc_next_s = sum_s[ACCW-1:0];
        end
`else
        acc_next_s = sum_s[ACCW-1:0];
`endif
    end

    // Run sequencer, valid pipe, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            issue_cnt_r   <= CNT_ZERO;
            vp_r          <= 2'b00;
            acc_r         <= {ACCW{1'b0}};
            overflow_r    <= 1'b0;
            issue_ready_r <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            vp_r <= {vp_r[0], fire_s};

            // vp_r[1] marks the cycle in which y holds the product of a fired issue.
            if (vp_r[1]) begin
                acc_r <= acc_next_s;
                if (sum_s[ACCW]) begin
                    overflow_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        issue_cnt_r <= len;
                        acc_r       <= {ACCW{1'b0}};
                        overflow_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        if (len == CNT_ZERO) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r       <= RUN;
                            issue_ready_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire_s) begin
                        issue_cnt_r <= issue_cnt_r - CNT_ONE;
                        if (issue_cnt_r == CNT_ONE) begin
                            state_r       <= DRAIN;
                            issue_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // With vp_r[0] clear, the only product still pending is the
                    // one vp_r[1] adds on this edge. Leaving now enters DONE on
                    // the edge of the last accumulation.
                    if (!vp_r[0]) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    issue_ready_r <= 1'b0;
                    out_valid_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign issue_ready = issue_ready_r;
    assign acc_out     = acc_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_mult_accumulate.sv
// -----------------------------------------------------------------------------
// tb_mult_accumulate
//
// Directed bench for mult_accumulate. A behavioural 2-cycle multiplier turns
// a/b into y. Inputs are driven and outputs are sampled on the falling clock
// edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mult_accumulate;

    localparam int WIDTH = 32;
    localparam int ACCW  = 64;
    localparam int LEN_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               issue_valid;
    logic               issue_ready;
    logic [2*WIDTH-1:0] y;
    logic [ACCW-1:0]    acc_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               overflow;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [WIDTH-1:0]   pa [8];
    logic [WIDTH-1:0]   pb [8];

    int n_cmp = 0;
    int n_bad = 0;
    int w;

    logic [63:0] ovf_exp;

    mult_accumulate #(.WIDTH(WIDTH), .ACCW(ACCW), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .y           (y),
        .acc_out     (acc_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: registers a/b, then the product on the next edge.
    always_ff @(posedge clk) begin
        a_q <= a;
        b_q <= b;
        y   <= 64'(a_q) * 64'(b_q);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Start a run and fire pa/pb[0..n-1], optionally with one idle cycle between fires.
    task automatic do_run(input int n, input bit gapped);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gapped && i > 0) begin
                issue_valid = 1'b0;
                tick();
            end
            check_eq("issue_ready_run", 64'(issue_ready), 64'd1);
            issue_valid = 1'b1;
            a = pa[i];
            b = pb[i];
            tick();
        end
        issue_valid = 1'b0;
        a = '0;
        b = '0;
    endtask

    // Count cycles after the last fire until out_valid rises, with a bound.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; issue_valid = 1'b0;
        out_ready = 1'b0; a = '0; b = '0;
        tick(); tick(); tick();
        check_eq("rst_issue_ready", 64'(issue_ready), 64'd0);
        check_eq("rst_out_valid",   64'(out_valid),   64'd0);
        check_eq("rst_busy",        64'(busy),        64'd0);
        check_eq("rst_acc",         acc_out,          64'd0);
        check_eq("rst_overflow",    64'(overflow),    64'd0);
        rst = 1'b0;
        tick();

        // Single product 3*5.
        pa[0] = 32'd3; pb[0] = 32'd5;
        do_run(1, 1'b0);
        check_eq("single_drain_ready", 64'(issue_ready), 64'd0);
        wait_valid(w);
        check_eq("single_latency", 64'(w), 64'd2);
        check_eq("single_acc",     acc_out, 64'd15);
        check_eq("single_ovf",     64'(overflow), 64'd0);
        accept();
        check_eq("single_idle_busy",  64'(busy), 64'd0);
        check_eq("single_idle_valid", 64'(out_valid), 64'd0);

        // Back-to-back run of four: 2+12+30+56 = 100.
        pa[0] = 32'd1; pb[0] = 32'd2;
        pa[1] = 32'd3; pb[1] = 32'd4;
        pa[2] = 32'd5; pb[2] = 32'd6;
        pa[3] = 32'd7; pb[3] = 32'd8;
        do_run(4, 1'b0);
        wait_valid(w);
        check_eq("b2b_latency", 64'(w), 64'd2);
        check_eq("b2b_acc",     acc_out, 64'd100);
        accept();

        // Gapped issue with back-pressure: 3 * 100 = 300.
        for (int i = 0; i < 3; i++) begin
            pa[i] = 32'd10;
            pb[i] = 32'd10;
        end
        do_run(3, 1'b1);
        wait_valid(w);
        check_eq("gap_latency", 64'(w), 64'd2);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_acc_stable",  acc_out, 64'd300);
            check_eq("bp_valid_held",  64'(out_valid), 64'd1);
            tick();
        end
        accept();
        check_eq("bp_idle_busy",  64'(busy), 64'd0);
        check_eq("bp_idle_valid", 64'(out_valid), 64'd0);

        // len == 0: done the cycle after start. A start during the handshake is ignored.
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        check_eq("len0_valid", 64'(out_valid), 64'd1);
        check_eq("len0_acc",   acc_out, 64'd0);
        check_eq("len0_ready", 64'(issue_ready), 64'd0);
        out_ready = 1'b1; start = 1'b1; len = 8'd1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check_eq("hs_start_ignored_busy",  64'(busy), 64'd0);
        check_eq("hs_start_ignored_ready", 64'(issue_ready), 64'd0);
        tick();
        check_eq("hs_still_idle", 64'(busy), 64'd0);

        // Overflow: two products of 0xFFFFFFFF^2 = 0xFFFFFFFE00000001.
`ifdef MACC_SATURATE_EN
        ovf_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        ovf_exp = 64'hFFFF_FFFC_0000_0002;
`endif
        pa[0] = 32'hFFFF_FFFF; pb[0] = 32'hFFFF_FFFF;
        pa[1] = 32'hFFFF_FFFF; pb[1] = 32'hFFFF_FFFF;
        do_run(2, 1'b0);
        wait_valid(w);
        check_eq("ovf_latency", 64'(w), 64'd2);
        check_eq("ovf_acc",     acc_out, ovf_exp);
        check_eq("ovf_flag",    64'(overflow), 64'd1);
        accept();

        // Reset after the second fire of a four-product run.
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'b1; a = 32'd9; b = 32'd9;
            tick();
        end
        issue_valid = 1'b0; a = '0; b = '0;
        rst = 1'b1;
        tick();
        check_eq("mrst_issue_ready", 64'(issue_ready), 64'd0);
        check_eq("mrst_out_valid",   64'(out_valid),   64'd0);
        check_eq("mrst_busy",        64'(busy),        64'd0);
        check_eq("mrst_acc",         acc_out,          64'd0);
        check_eq("mrst_overflow",    64'(overflow),    64'd0);
        rst = 1'b0;
        pa[0] = 32'd2; pb[0] = 32'd3;
        do_run(1, 1'b0);
        wait_valid(w);
        check_eq("post_rst_latency", 64'(w), 64'd2);
        check_eq("post_rst_acc",     acc_out, 64'd6);
        check_eq("post_rst_ovf",     64'(overflow), 64'd0);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
